// File: rtl/rrp_arbiter_burst.sv
// ============================================================================
// Module   : rrp_arbiter_burst
// Purpose  : N-channel round-robin merge of first-word-fall-through source
//            FIFOs into one registered output stream. The burst length per
//            ownership is capped, a per-channel hold extends ownership, and a
//            downstream ready stalls grants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rrp_arbiter_burst #(
  parameter int WIDTH      = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [WIDTH-1:0]            WRITE_REQ,
  input  logic [WIDTH-1:0]            HOLD_REQ,
  input  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN,
  input  logic                        READY_IN,
  output logic [WIDTH-1:0]            READ_GRANT,
  output logic                        WRITE_OUT,
  output logic [DATA_WIDTH-1:0]       DATA_OUT,
  output logic [$clog2(WIDTH)-1:0]    GRANT_CH,
  output logic                        BUSY
);

  localparam int c_IDX_W = $clog2(WIDTH);
  // A zero cap still needs a 1-bit counter so the register is legal.
  localparam int c_CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [c_CNT_W-1:0] c_CAP       = c_CNT_W'(MAX_BURST);
  localparam logic [c_IDX_W-1:0] c_LAST_CH   = c_IDX_W'(WIDTH - 1);
  localparam bit                 c_UNLIMITED = (MAX_BURST == 0);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t                r_state;
  logic [c_IDX_W-1:0]    r_last;
  logic [c_IDX_W-1:0]    r_owner;
  logic [c_IDX_W-1:0]    r_grant_ch;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_write_out;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic [DATA_WIDTH-1:0] w_din [WIDTH];
  logic [WIDTH-1:0]      w_any;
  logic [WIDTH-1:0]      w_hi_req;
  logic [WIDTH-1:0]      w_pick;
  logic [c_IDX_W-1:0]    w_start;
  logic [c_IDX_W-1:0]    w_sel;
  logic                  w_own_wreq;
  logic                  w_own_hold;
  logic                  w_under_cap;
  logic                  w_grant;
  logic                  w_release;

  // Split the flat data bus into one word per channel.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_din
      assign w_din[gi] = DATA_IN[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_any       = WRITE_REQ | HOLD_REQ;
  assign w_start     = (r_last == c_LAST_CH) ? '0 : r_last + 1'b1;
  assign w_own_wreq  = WRITE_REQ[r_owner];
  assign w_own_hold  = HOLD_REQ[r_owner];
  assign w_under_cap = c_UNLIMITED || (r_cnt < c_CAP);
  assign w_grant     = (r_state == S_GRANT) && w_own_wreq && READY_IN &&
                       (w_under_cap || w_own_hold);
  // Release never coincides with a grant: both terms exclude a grant.
  assign w_release   = (r_state == S_GRANT) && !w_own_hold &&
                       (!w_own_wreq || (!c_UNLIMITED && (r_cnt >= c_CAP)));

  // Round-robin pick: lowest requester at or above w_start, else lowest overall.
  always_comb begin
    w_hi_req = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_hi_req[k] = w_any[k] && (c_IDX_W'(k) >= w_start);
    end
    w_pick = (|w_hi_req) ? w_hi_req : w_any;
    w_sel  = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (w_pick[k]) begin
        w_sel = c_IDX_W'(k);
      end
    end
  end

  // One-hot pop strobe to the current owner only.
  always_comb begin
    READ_GRANT = '0;
    if (w_grant) begin
      READ_GRANT[r_owner] = 1'b1;
    end
  end

  // Ownership FSM plus the registered output word.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_last      <= c_LAST_CH;
      r_owner     <= '0;
      r_grant_ch  <= '0;
      r_cnt       <= '0;
      r_write_out <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_write_out <= w_grant;
      if (w_grant) begin
        r_data_out <= w_din[r_owner];
      end
      case (r_state)
        S_IDLE: begin
          if (|w_any) begin
            r_owner    <= w_sel;
            r_grant_ch <= w_sel;
            r_cnt      <= '0;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_last  <= r_owner;
            r_state <= S_IDLE;
          end else if (w_grant && !c_UNLIMITED && (r_cnt < c_CAP)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign WRITE_OUT = r_write_out;
  assign DATA_OUT  = r_data_out;
  assign GRANT_CH  = r_grant_ch;
  assign BUSY      = (r_state == S_GRANT);

endmodule

`default_nettype wire

// File: tb/tb_rrp_arbiter_burst.sv
// ============================================================================
// Module   : tb_rrp_arbiter_burst
// Purpose  : Self-checking bench for rrp_arbiter_burst. Two instances run side
//            by side: MAX_BURST=4 and MAX_BURST=0 (unlimited). Source FIFOs
//            are modelled as arrays; a behavioural model predicts every output
//            each cycle, and directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rrp_arbiter_burst;

  localparam int W     = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  wreq [2];
  logic [W-1:0]  hold [2];
  logic [W-1:0]  rg   [2];
  logic          ready[2];
  logic          wo   [2];
  logic          busy [2];
  logic [W*DW-1:0] din [2];
  logic [DW-1:0] dout [2];
  logic [2:0]    gch  [2];

  rrp_arbiter_burst #(.WIDTH(W), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .WRITE_REQ(wreq[0]), .HOLD_REQ(hold[0]),
    .DATA_IN(din[0]), .READY_IN(ready[0]), .READ_GRANT(rg[0]),
    .WRITE_OUT(wo[0]), .DATA_OUT(dout[0]), .GRANT_CH(gch[0]), .BUSY(busy[0])
  );

  rrp_arbiter_burst #(.WIDTH(W), .DATA_WIDTH(DW), .MAX_BURST(0)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .WRITE_REQ(wreq[1]), .HOLD_REQ(hold[1]),
    .DATA_IN(din[1]), .READY_IN(ready[1]), .READ_GRANT(rg[1]),
    .WRITE_OUT(wo[1]), .DATA_OUT(dout[1]), .GRANT_CH(gch[1]), .BUSY(busy[1])
  );

  // Source FIFO contents per instance and channel
  int          maxb[2];
  logic [DW-1:0] mem[2][W][DEPTH];
  int          hd  [2][W];
  int          fcnt[2][W];
  int          pushed[2];
  int          dgc [2][W];   // grants observed on the DUT pins
  bit          chk_en;

  // Behavioural model state
  bit          m_busy [2];
  int          m_owner[2];
  int          m_last [2];
  int          m_cnt  [2];
  int          m_gch  [2];
  bit          m_wout [2];
  logic [DW-1:0] m_dout[2];
  bit          e_g  [2];
  bit          e_rel[2];

  task automatic chk(input string nm, input int d, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < W; c++) begin
        wreq[d][c] = (fcnt[d][c] != 0);
        din[d][c*DW +: DW] = (fcnt[d][c] != 0) ? mem[d][c][hd[d][c]] : (32'hBAD0_0000 | 32'(c));
      end
    end
  endtask

  task automatic push(input int d, input int c);
    if (fcnt[d][c] < DEPTH) begin
      mem[d][c][(hd[d][c] + fcnt[d][c]) % DEPTH] = {d[3:0], c[3:0], pushed[d][23:0]};
      fcnt[d][c]++;
      pushed[d]++;
    end
    drive();
  endtask

  task automatic pop(input int d, input int c, output logic [DW-1:0] w);
    w = mem[d][c][hd[d][c]];
    hd[d][c] = (hd[d][c] + 1) % DEPTH;
    fcnt[d][c]--;
  endtask

  // Mid-cycle: predict combinational grant/release and compare all outputs.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int own;
      bit ok;
      own      = m_owner[d];
      e_g[d]   = 1'b0;
      e_rel[d] = 1'b0;
      if (m_busy[d]) begin
        ok       = (maxb[d] == 0) || (m_cnt[d] < maxb[d]) || hold[d][own];
        e_g[d]   = wreq[d][own] && ready[d] && ok;
        e_rel[d] = !hold[d][own] &&
                   (!wreq[d][own] || (maxb[d] != 0 && m_cnt[d] >= maxb[d]));
      end
      if (chk_en) begin
        chk("READ_GRANT", d, 64'(rg[d]), e_g[d] ? (64'd1 << own) : 64'd0);
        chk("WRITE_OUT",  d, 64'(wo[d]), 64'(m_wout[d]));
        chk("DATA_OUT",   d, 64'(dout[d]), 64'(m_dout[d]));
        chk("GRANT_CH",   d, 64'(gch[d]), 64'(m_gch[d]));
        chk("BUSY",       d, 64'(busy[d]), 64'(m_busy[d]));
      end
      for (int c = 0; c < W; c++) begin
        if (rg[d][c] === 1'b1) dgc[d][c]++;
      end
    end
  endtask

  // Just after the edge: advance the model and the source FIFOs.
  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [DW-1:0] w;
      w = '0;
      if (e_g[d]) pop(d, m_owner[d], w);
      if (!rst_n) begin
        m_busy[d] = 1'b0; m_last[d] = W - 1; m_owner[d] = 0;
        m_cnt[d] = 0; m_gch[d] = 0; m_wout[d] = 1'b0; m_dout[d] = '0;
      end else if (!m_busy[d]) begin
        m_wout[d] = 1'b0;
        if ((wreq[d] | hold[d]) != '0) begin
          bit found;
          int sel;
          found = 1'b0;
          sel   = 0;
          for (int k = 1; k <= W; k++) begin
            int idx;
            idx = (m_last[d] + k) % W;
            if (!found && (wreq[d][idx] || hold[d][idx])) begin
              sel   = idx;
              found = 1'b1;
            end
          end
          m_owner[d] = sel; m_gch[d] = sel; m_cnt[d] = 0; m_busy[d] = 1'b1;
        end
      end else begin
        m_wout[d] = e_g[d];
        if (e_g[d]) m_dout[d] = w;
        if (e_rel[d]) begin
          m_last[d] = m_owner[d];
          m_busy[d] = 1'b0;
        end else if (e_g[d] && maxb[d] != 0 && m_cnt[d] < maxb[d]) begin
          m_cnt[d]++;
        end
      end
    end
    drive();
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      tick();
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int guard;
    int left;
    bit rp[4];
    maxb   = '{4, 0};
    rst_n  = 1'b0;
    ready  = '{1'b1, 1'b1};
    hold   = '{'0, '0};
    chk_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      pushed[d] = 0;
      for (int c = 0; c < W; c++) begin
        hd[d][c] = 0; fcnt[d][c] = 0; dgc[d][c] = 0;
      end
    end
    drive();

    // Reset with every channel requesting (10 words each)
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < W; c++)
        repeat (10) push(d, c);
    tick();
    step();
    chk_en = 1'b1;
    repeat (2) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        chk("RST_READ_GRANT", d, 64'(rg[d]), 64'd0);
        chk("RST_WRITE_OUT",  d, 64'(wo[d]), 64'd0);
        chk("RST_DATA_OUT",   d, 64'(dout[d]), 64'd0);
        chk("RST_BUSY",       d, 64'(busy[d]), 64'd0);
      end
      step();
    end
    rst_n = 1'b1;

    // First grant after reset goes to channel 0, one cycle after selection
    cyc(1);
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("FIRST_GRANT", d, 64'(rg[d]), 64'h1);
      chk("FIRST_CH",    d, 64'(gch[d]), 64'h0);
    end
    step();

    // Fairness: 80 cycles from reset release drain 50 words at cap 4
    cyc(78);
    chk("FAIR_BUSY", 0, 64'(busy[0]), 64'd0);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < W; c++)
        chk("FAIR_COUNT", d, 64'(dgc[d][c]), 64'd10);

    // Hold overrides the burst cap on channel 0
    hold[0] = 5'b00001;
    repeat (8) push(0, 0);
    repeat (3) push(0, 1);
    b = dgc[0][0];
    cyc(10);
    chk("HOLD_CAP_GRANTS", 0, 64'(dgc[0][0] - b), 64'd8);
    chk("HOLD_CAP_BUSY",   0, 64'(busy[0]), 64'd1);
    hold[0] = '0;
    cyc(2);
    chk("HOLD_NEXT_CH", 0, 64'(gch[0]), 64'd1);
    cyc(6);

    // Hold while empty keeps channel 2 owning with no grants
    hold[0] = 5'b00100;
    repeat (4) push(0, 3);
    cyc(1);
    repeat (6) begin
      tick();
      chk("HOLD_EMPTY_RG",   0, 64'(rg[0]), 64'd0);
      chk("HOLD_EMPTY_BUSY", 0, 64'(busy[0]), 64'd1);
      chk("HOLD_EMPTY_CH",   0, 64'(gch[0]), 64'd2);
      step();
    end
    hold[0] = '0;
    cyc(2);
    chk("AFTER_HOLD_CH", 0, 64'(gch[0]), 64'd3);
    cyc(8);

    // Back-pressure during a channel 1 burst
    repeat (4) push(0, 1);
    cyc(1);
    b  = dgc[0][1];
    rp = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      ready[0] = rp[i];
      tick();
      if (!rp[i]) chk("STALL_RG", 0, 64'(rg[0]), 64'd0);
      step();
    end
    chk("STALL_GRANTS", 0, 64'(dgc[0][1] - b), 64'd2);
    ready[0] = 1'b1;
    cyc(6);
    chk("STALL_TOTAL", 0, 64'(dgc[0][1] - b), 64'd4);

    // Unlimited burst on instance 1, then wrap from channel 4 to channel 0
    repeat (100) push(1, 4);
    b = dgc[1][4];
    cyc(101);
    chk("UNLIM_GRANTS", 1, 64'(dgc[1][4] - b), 64'd100);
    chk("UNLIM_BUSY",   1, 64'(busy[1]), 64'd1);
    push(1, 0);
    cyc(2);
    chk("WRAP_CH", 1, 64'(gch[1]), 64'd0);
    cyc(4);

    // Randomised traffic, hold and back-pressure on both instances
    repeat (3000) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < W; c++) begin
          if ($urandom_range(0, 99) < 10 && fcnt[d][c] < 200) push(d, c);
          hold[d][c] = ($urandom_range(0, 99) < 6);
        end
        ready[d] = ($urandom_range(0, 3) != 0);
      end
      cyc(1);
    end

    // Drain everything with a bounded wait
    hold  = '{'0, '0};
    ready = '{1'b1, 1'b1};
    guard = 0;
    left  = 1;
    while (left != 0 && guard < 3000) begin
      cyc(1);
      guard++;
      left = 0;
      for (int d = 0; d < 2; d++) begin
        if (m_busy[d]) left++;
        for (int c = 0; c < W; c++) left += fcnt[d][c];
      end
    end
    chk("DRAIN_LEFT", 0, 64'(left), 64'd0);
    for (int d = 0; d < 2; d++) chk("DRAIN_BUSY", d, 64'(busy[d]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
